fan_thermal_scheduler: RTL

//  Periodic thermal controller that drives the PWM fan generator's duty (pulse_length) input.
//  - Each update tick, scans core temperature sensors round-robin over a req/ack handshake.
//  - Takes the max temperature, maps it to a target duty with hysteresis, and slew-limits the applied duty.
//  - Supervises the fan tachometer and forces full speed with a sticky fault if the fan stalls.

---
 rtl/fan_thermal_scheduler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/fan_thermal_scheduler.sv
`default_nettype none
// ============================================================================
// fan_thermal_scheduler
// Per-tick round-robin temperature scan driving fan PWM duty with hysteresis,
// slew limiting and tachometer stall supervision.
// Rev 1.0
// ============================================================================
module fan_thermal_scheduler #(
  parameter int NUM_CORES   = 3,
  parameter int TICK_DIV    = 6400,
  parameter int LOW_T       = 50,
  parameter int HIGH_T      = 70,
  parameter int MIN_DUTY    = 25,
  parameter int HYST        = 3,
  parameter int STEP        = 16,
  parameter int STALL_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic       sens_req,
  output logic [1:0] sens_sel,
  input  logic       sens_ack,
  input  logic [7:0] sens_data,
  input  logic       tach,
  output logic [7:0] duty,
  output logic       duty_upd,
  output logic [7:0] max_temp,
  output logic       fan_fault
);

  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCW = $clog2(STALL_TICKS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CALC  = 3'd3;
  localparam logic [2:0] S_SLEW  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic [2:0]     r_state;
  logic [2:0]     w_next;
  logic [TCW-1:0] r_tick_cnt;
  logic           w_tick;
  logic           r_tach_s1;
  logic           r_tach_s2;
  logic           r_tach_d;
  logic           w_tach_edge;
  logic [SCW-1:0] r_stall;
  logic           w_stall_hit;
  logic [1:0]     r_idx;
  logic [7:0]     r_scan_max;
  logic [7:0]     r_max_temp;
  logic [7:0]     r_target;
  logic [7:0]     r_ref;
  logic [7:0]     r_duty;
  logic           r_duty_upd;
  logic           r_fault;

  logic [15:0]    w_prod;
  logic [15:0]    w_lin;
  logic [7:0]     w_raw;
  logic           w_block;
  logic           w_accept;
  logic [7:0]     w_target;
  logic [7:0]     w_diff;
  logic [7:0]     w_step;
  logic [7:0]     w_duty_next;

  assign w_tick      = (r_tick_cnt == TCW'(TICK_DIV - 1));
  assign w_tach_edge = r_tach_s2 & ~r_tach_d;
  assign w_stall_hit = (r_state != S_FAULT) && w_tick && !w_tach_edge &&
                       (r_duty != 8'd0) && (r_stall == SCW'(STALL_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_tach_s1  <= 1'b0;
      r_tach_s2  <= 1'b0;
      r_tach_d   <= 1'b0;
      r_stall    <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_tach_s1  <= tach;
      r_tach_s2  <= r_tach_s1;
      r_tach_d   <= r_tach_s2;
      if (w_tach_edge)
        r_stall <= '0;
      else if (w_tick && (r_duty != 8'd0) && (r_state != S_FAULT) &&
               (r_stall != SCW'(STALL_TICKS)))
        r_stall <= r_stall + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_tick) w_next = S_REQ;
      S_REQ:   w_next = S_WAIT;
      S_WAIT:  if (sens_ack)
                 w_next = (r_idx < 2'(NUM_CORES - 1)) ? S_REQ : S_CALC;
      S_CALC:  w_next = S_SLEW;
      S_SLEW:  w_next = S_IDLE;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_IDLE;
    endcase
    if (w_stall_hit) w_next = S_FAULT;
  end

  // Linear map between LOW_T and HIGH_T; hysteresis holds decreases until
  // the temperature has fallen HYST below the last accepted reading.
  always_comb begin
    w_prod = 16'(255 - MIN_DUTY) * 16'(r_scan_max - 8'(LOW_T));
    w_lin  = 16'(MIN_DUTY) + w_prod / 16'(HIGH_T - LOW_T);
    if (r_scan_max <= 8'(LOW_T))
      w_raw = 8'(MIN_DUTY);
    else if (r_scan_max > 8'(HIGH_T))
      w_raw = 8'd255;
    else
      w_raw = (w_lin > 16'd255) ? 8'd255 : w_lin[7:0];
    w_block  = (w_raw < r_duty) &&
               ((9'(r_scan_max) + 9'(HYST)) > 9'(r_ref));
    w_target = w_block ? r_duty : w_raw;
    w_accept = !w_block && (w_raw != r_duty);
  end

  always_comb begin
    w_diff      = (r_target >= r_duty) ? (r_target - r_duty) : (r_duty - r_target);
    w_step      = (w_diff > 8'(STEP)) ? 8'(STEP) : w_diff;
    w_duty_next = (r_target >= r_duty) ? (r_duty + w_step) : (r_duty - w_step);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= 2'd0;
      r_scan_max <= 8'd0;
      r_max_temp <= 8'd0;
      r_target   <= 8'(MIN_DUTY);
      r_ref      <= 8'd0;
      r_duty     <= 8'(MIN_DUTY);
      r_duty_upd <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_duty_upd <= 1'b0;
      if (w_stall_hit) begin
        r_fault    <= 1'b1;
        r_duty     <= 8'd255;
        r_duty_upd <= (r_duty != 8'd255);
      end else begin
        case (r_state)
          S_IDLE: if (w_tick) begin
            r_scan_max <= 8'd0;
            r_idx      <= 2'd0;
          end
          S_WAIT: if (sens_ack) begin
            if (sens_data > r_scan_max) r_scan_max <= sens_data;
            if (r_idx < 2'(NUM_CORES - 1)) r_idx <= r_idx + 2'd1;
          end
          S_CALC: begin
            r_max_temp <= r_scan_max;
            r_target   <= w_target;
            if (w_accept) r_ref <= r_scan_max;
          end
          S_SLEW: begin
            r_duty     <= w_duty_next;
            r_duty_upd <= (w_duty_next != r_duty);
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    sens_req  = (r_state == S_WAIT);
    sens_sel  = r_idx;
    duty      = r_duty;
    duty_upd  = r_duty_upd;
    max_temp  = r_max_temp;
    fan_fault = r_fault;
  end

endmodule
`default_nettype wire
